// File: rtl/iic_rw_pkg.sv
// Shared types and constants for the IIC EEPROM write/read-back self-test.
package iic_rw_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_WAIT_TIMER,
      ST_RD_REQ,
      ST_DONE
   } state_t;

   localparam logic IIC_OP_WR = 1'b1;
   localparam logic IIC_OP_RD = 1'b0;

   localparam logic [7:0] DEFAULT_SEED    = 8'hA5;
   localparam int         DEFAULT_WR_WAIT = 250_000;

   // Address and pattern data both advance as base + index, wrapping at 256.
   function automatic logic [7:0] offset_byte(input logic [7:0] base, input logic [7:0] idx);
      return base + idx;
   endfunction

endpackage

// File: rtl/iic_rw_check_if.sv
// Request/acknowledge link between the self-test sequencer and the IIC byte master.
interface iic_rw_check_if;

   logic       iic_req;
   logic       iic_wr;
   logic [7:0] iic_addr;
   logic [7:0] iic_wdata;
   logic       iic_ack;
   logic       iic_nack;
   logic [7:0] iic_rdata;

   modport master (
      output iic_req, iic_wr, iic_addr, iic_wdata,
      input  iic_ack, iic_nack, iic_rdata
   );

   modport slave (
      input  iic_req, iic_wr, iic_addr, iic_wdata,
      output iic_ack, iic_nack, iic_rdata
   );

endinterface

// File: rtl/rw_delay_timer.sv
// One-shot delay: after i_load, pulses o_expired once, WR_WAIT cycles later.
module rw_delay_timer #(
   parameter int WR_WAIT = 250_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   output logic o_expired
);

   localparam int            TW       = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;
   localparam logic [TW-1:0] LAST_CNT = TW'(WR_WAIT - 1);

   logic [TW-1:0] r_count;
   logic          r_running;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count   <= '0;
         r_running <= 1'b0;
      end else if (i_load) begin
         r_count   <= '0;
         r_running <= 1'b1;
      end else if (r_running) begin
         if (r_count == LAST_CNT) begin
            r_running <= 1'b0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_expired = r_running && (r_count == LAST_CNT);

endmodule

// File: rtl/iic_rw_check.sv
// EEPROM self-test: writes NUM_BYTES pattern bytes, waits the write-cycle time,
// reads them back and reports pass/fail on o_rw_done / o_rw_result.
module iic_rw_check
   import iic_rw_pkg::*;
#(
   parameter int         NUM_BYTES = 8,
   parameter logic [7:0] BASE_ADDR = 8'h00,
   parameter logic [7:0] SEED      = DEFAULT_SEED,
   parameter int         WR_WAIT   = DEFAULT_WR_WAIT
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_start,
   iic_rw_check_if.master iic,
   output logic           o_rw_done,
   output logic           o_rw_result,
   output logic           o_busy
);

   localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

   state_t     r_state,  w_state_nxt;
   logic [7:0] r_index,  w_index_nxt;
   logic       r_req,    w_req_nxt;
   logic       r_wr,     w_wr_nxt;
   logic [7:0] r_addr,   w_addr_nxt;
   logic [7:0] r_wdata,  w_wdata_nxt;
   logic       r_done,   w_done_nxt;
   logic       r_result, w_result_nxt;
   logic       r_busy,   w_busy_nxt;
   logic       w_timer_load;
   logic       w_timer_expired;
   logic       w_ack;

   rw_delay_timer #(.WR_WAIT(WR_WAIT)) u_delay_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_timer_load),
      .o_expired (w_timer_expired)
   );

   // Acks arriving with no request outstanding are stray and must not advance anything.
   assign w_ack = iic.iic_ack && r_req;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_index  <= '0;
         r_req    <= 1'b0;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_done   <= 1'b0;
         r_result <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_index  <= w_index_nxt;
         r_req    <= w_req_nxt;
         r_wr     <= w_wr_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_done   <= w_done_nxt;
         r_result <= w_result_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a hold value first, so no path
      // through the case leaves one unassigned and infers a latch.
      w_state_nxt  = r_state;
      w_index_nxt  = r_index;
      w_req_nxt    = r_req;
      w_wr_nxt     = r_wr;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_done_nxt   = r_done;
      w_result_nxt = r_result;
      w_busy_nxt   = r_busy;
      w_timer_load = 1'b0;

      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               w_state_nxt  = ST_WR_REQ;
               w_index_nxt  = '0;
               w_busy_nxt   = 1'b1;
               w_done_nxt   = 1'b0;
               w_result_nxt = 1'b0;
               w_req_nxt    = 1'b1;
               w_wr_nxt     = IIC_OP_WR;
               w_addr_nxt   = BASE_ADDR;
               w_wdata_nxt  = SEED;
            end
         end

         // With req low, the cycle after an ack serves as the mandatory idle gap.
         ST_WR_REQ: begin
            if (!r_req) begin
               w_req_nxt   = 1'b1;
               w_wr_nxt    = IIC_OP_WR;
               w_addr_nxt  = offset_byte(BASE_ADDR, r_index);
               w_wdata_nxt = offset_byte(SEED, r_index);
            end else if (w_ack) begin
               w_req_nxt = 1'b0;
               if (iic.iic_nack) begin
                  w_state_nxt  = ST_DONE;
                  w_done_nxt   = 1'b1;
                  w_result_nxt = 1'b0;
                  w_busy_nxt   = 1'b0;
               end else if (r_index == LAST_IDX) begin
                  w_state_nxt  = ST_WR_WAIT_TIMER;
                  w_timer_load = 1'b1;
               end else begin
                  w_index_nxt = r_index + 1'b1;
               end
            end
         end

         ST_WR_WAIT_TIMER: begin
            if (w_timer_expired) begin
               w_state_nxt = ST_RD_REQ;
               w_index_nxt = '0;
               w_wr_nxt    = IIC_OP_RD;
               w_addr_nxt  = BASE_ADDR;
            end
         end

         ST_RD_REQ: begin
            if (!r_req) begin
               w_req_nxt  = 1'b1;
               w_wr_nxt   = IIC_OP_RD;
               w_addr_nxt = offset_byte(BASE_ADDR, r_index);
            end else if (w_ack) begin
               w_req_nxt = 1'b0;
               if (iic.iic_nack || (iic.iic_rdata != offset_byte(SEED, r_index))) begin
                  w_state_nxt  = ST_DONE;
                  w_done_nxt   = 1'b1;
                  w_result_nxt = 1'b0;
                  w_busy_nxt   = 1'b0;
               end else if (r_index == LAST_IDX) begin
                  w_state_nxt  = ST_DONE;
                  w_done_nxt   = 1'b1;
                  w_result_nxt = 1'b1;
                  w_busy_nxt   = 1'b0;
               end else begin
                  w_index_nxt = r_index + 1'b1;
               end
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign iic.iic_req   = r_req;
   assign iic.iic_wr    = r_wr;
   assign iic.iic_addr  = r_addr;
   assign iic.iic_wdata = r_wdata;
   assign o_rw_done     = r_done;
   assign o_rw_result   = r_result;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_iic_rw_check.sv
// Self-checking bench: two sequencer instances driven by an EEPROM-like byte master model.
module tb_iic_rw_check;

   localparam int W0 = 200;
   localparam int W1 = 37;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   logic start0, start1;
   logic done0, res0, busy0, done1, res1, busy1;

   always #5 clk = ~clk;

   iic_rw_check_if if0();
   iic_rw_check_if if1();

   iic_rw_check #(.NUM_BYTES(8), .BASE_ADDR(8'h00), .SEED(8'hA5), .WR_WAIT(W0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(start0), .iic(if0),
      .o_rw_done(done0), .o_rw_result(res0), .o_busy(busy0)
   );

   iic_rw_check #(.NUM_BYTES(4), .BASE_ADDR(8'hFE), .SEED(8'hFF), .WR_WAIT(W1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start1), .iic(if1),
      .o_rw_done(done1), .o_rw_result(res1), .o_busy(busy1)
   );

   // Byte-master model state, one slot per instance
   logic       ack_o   [2];
   logic       nack_o  [2];
   logic [7:0] rdata_o [2];
   logic [7:0] mem     [2][256];
   int         pend[2], cnt[2], lat[2], wr_count[2], nack_at[2];
   bit         corrupt_en[2], rd_seen[2];
   logic [7:0] corrupt_addr[2], corrupt_val[2];
   logic       cap_wr[2];
   logic [7:0] cap_addr[2], cap_wdata[2];
   int         last_wr_ack_cyc[2], first_rd_cyc[2], nack_cyc[2], done_cyc[2];
   txn_t       log_q[2][$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   assign if0.iic_ack   = ack_o[0];
   assign if0.iic_nack  = nack_o[0];
   assign if0.iic_rdata = rdata_o[0];
   assign if1.iic_ack   = ack_o[1];
   assign if1.iic_nack  = nack_o[1];
   assign if1.iic_rdata = rdata_o[1];

   task automatic snap(input int d, output logic [20:0] v);
      if (d == 0) v = {if0.iic_req, if0.iic_wr, if0.iic_addr, if0.iic_wdata, done0, res0, busy0};
      else        v = {if1.iic_req, if1.iic_wr, if1.iic_addr, if1.iic_wdata, done1, res1, busy1};
   endtask

   task automatic slave_step(input int d);
      logic [20:0] v;
      logic        req, wr;
      logic [7:0]  addr, wdata;
      snap(d, v);
      {req, wr, addr, wdata} = v[20:3];
      if (ack_o[d]) begin
         ack_o[d]  = 1'b0;
         nack_o[d] = 1'b0;
         pend[d]   = 0;
      end else if (!req) begin
         pend[d] = 0;
      end else begin
         if (pend[d] == 0) begin
            pend[d]      = 1;
            cnt[d]       = 0;
            cap_wr[d]    = wr;
            cap_addr[d]  = addr;
            cap_wdata[d] = wdata;
            if (!wr && !rd_seen[d]) begin
               rd_seen[d]      = 1'b1;
               first_rd_cyc[d] = cyc;
            end
         end
         cnt[d]++;
         if (cnt[d] >= lat[d]) begin
            n_checks++;
            if ({wr, addr} !== {cap_wr[d], cap_addr[d]} || (wr && wdata !== cap_wdata[d])) begin
               n_fail++;
               $display("FAIL req_stable dut%0d: got wr=%b addr=%h wdata=%h, want wr=%b addr=%h wdata=%h",
                        d, wr, addr, wdata, cap_wr[d], cap_addr[d], cap_wdata[d]);
            end
            if (wr) begin
               wr_count[d]++;
               last_wr_ack_cyc[d] = cyc;
               if (wr_count[d] == nack_at[d]) begin
                  nack_o[d]   = 1'b1;
                  nack_cyc[d] = cyc;
               end else begin
                  mem[d][addr] = wdata;
               end
               log_q[d].push_back('{wr: 1'b1, addr: addr, data: wdata});
            end else begin
               rdata_o[d] = (corrupt_en[d] && addr == corrupt_addr[d]) ? corrupt_val[d] : mem[d][addr];
               log_q[d].push_back('{wr: 1'b0, addr: addr, data: rdata_o[d]});
            end
            ack_o[d] = 1'b1;
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         ack_o[d] = 1'b0; nack_o[d] = 1'b0; rdata_o[d] = 8'h00;
         pend[d] = 0; cnt[d] = 0; lat[d] = 10; wr_count[d] = 0; nack_at[d] = 0;
         corrupt_en[d] = 1'b0; rd_seen[d] = 1'b0;
      end
      forever begin
         @(negedge clk);
         slave_step(0);
         slave_step(1);
      end
   end

   task automatic new_run(input int d, input int latency);
      log_q[d].delete();
      wr_count[d]   = 0;
      nack_at[d]    = 0;
      corrupt_en[d] = 1'b0;
      rd_seen[d]    = 1'b0;
      lat[d]        = latency;
   endtask

   task automatic pulse_start(input int d);
      @(negedge clk); #1;
      if (d == 0) start0 = 1'b1; else start1 = 1'b1;
      @(negedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget);
      logic [20:0] v;
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         snap(d, v);
         if (v[2]) begin
            ok = 1'b1;
            done_cyc[d] = cyc;
         end
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL done_timeout dut%0d: rw_done still 0 after %0d cycles, want 1", d, budget);
      end
   endtask

   // Expected bus traffic comes straight from the address/pattern rules.
   task automatic check_log(input int d, input logic [7:0] base, input logic [7:0] seed,
                            input int n, input int nack_wr, input int n_reads);
      txn_t exp_q[$];
      int   nw = (nack_wr != 0) ? nack_wr : n;
      for (int i = 0; i < nw; i++) exp_q.push_back('{wr: 1'b1, addr: 8'(base + i), data: 8'(seed + i)});
      for (int i = 0; i < n_reads; i++) exp_q.push_back('{wr: 1'b0, addr: 8'(base + i), data: 8'h00});
      n_checks++;
      if (log_q[d].size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL txn_count dut%0d: got %0d transactions, want %0d", d, log_q[d].size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (log_q[d][i].wr !== exp_q[i].wr || log_q[d][i].addr !== exp_q[i].addr ||
                (exp_q[i].wr && log_q[d][i].data !== exp_q[i].data)) begin
               n_fail++;
               $display("FAIL txn[%0d] dut%0d: got wr=%b addr=%h data=%h, want wr=%b addr=%h data=%h",
                        i, d, log_q[d][i].wr, log_q[d][i].addr, log_q[d][i].data,
                        exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
         end
      end
   endtask

   task automatic check_final(input int d, input logic exp_res);
      logic [20:0] v;
      snap(d, v);
      n_checks++;
      if ({v[20], v[2:0]} !== {1'b0, 1'b1, exp_res, 1'b0}) begin
         n_fail++;
         $display("FAIL final_status dut%0d: got req=%b done=%b result=%b busy=%b, want req=0 done=1 result=%b busy=0",
                  d, v[20], v[2], v[1], v[0], exp_res);
      end
   endtask

   task automatic check_gap(input int d, input int w);
      int gap = first_rd_cyc[d] - last_wr_ack_cyc[d];
      n_checks++;
      if (!rd_seen[d] || gap < w || gap > w + 4) begin
         n_fail++;
         $display("FAIL write_gap dut%0d: got %0d cycles, want %0d..%0d", d, gap, w, w + 4);
      end
   endtask

   task automatic check_started(input int d, input logic [7:0] base, input logic [7:0] seed);
      logic [20:0] v;
      snap(d, v);
      n_checks++;
      if (v !== {1'b1, 1'b1, base, seed, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL start_state dut%0d: got %h, want %h", d, v, {1'b1, 1'b1, base, seed, 3'b001});
      end
   endtask

   task automatic test_reset();
      logic [20:0] v;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         snap(d, v);
         n_checks++;
         if (v !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: got %h, want 000000", d, v);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_default_pass();
      new_run(0, 10);
      pulse_start(0);
      check_started(0, 8'h00, 8'hA5);
      wait_done(0, 3000);
      check_final(0, 1'b1);
      check_log(0, 8'h00, 8'hA5, 8, 0, 8);
      check_gap(0, W0);
   endtask

   task automatic test_corrupt_read();
      int sz;
      logic [20:0] v;
      new_run(0, 10);
      corrupt_en[0] = 1'b1; corrupt_addr[0] = 8'h03; corrupt_val[0] = 8'h00;
      pulse_start(0);
      wait_done(0, 3000);
      check_final(0, 1'b0);
      check_log(0, 8'h00, 8'hA5, 8, 0, 4);
      sz = log_q[0].size();
      repeat (30) @(negedge clk);
      #1;
      snap(0, v);
      n_checks++;
      if (log_q[0].size() != sz || v[20] !== 1'b0) begin
         n_fail++;
         $display("FAIL quiet_after_fail: got %0d txns req=%b, want %0d txns req=0", log_q[0].size(), v[20], sz);
      end
   endtask

   task automatic test_nack_write();
      new_run(0, 10);
      nack_at[0] = 2;
      pulse_start(0);
      wait_done(0, 3000);
      check_final(0, 1'b0);
      check_log(0, 8'h00, 8'hA5, 8, 2, 0);
      n_checks++;
      if (done_cyc[0] != nack_cyc[0] + 1) begin
         n_fail++;
         $display("FAIL nack_latency: rw_done seen %0d cycles after nack ack, want 1", done_cyc[0] - nack_cyc[0]);
      end
   endtask

   task automatic test_wrap();
      new_run(1, 4);
      pulse_start(1);
      check_started(1, 8'hFE, 8'hFF);
      wait_done(1, 2000);
      check_final(1, 1'b1);
      check_log(1, 8'hFE, 8'hFF, 4, 0, 4);
      check_gap(1, W1);
   endtask

   task automatic test_random_faults();
      int k;
      repeat (3) begin
         k = $urandom_range(0, 7);
         new_run(0, $urandom_range(1, 12));
         corrupt_en[0] = 1'b1; corrupt_addr[0] = 8'(k); corrupt_val[0] = ~8'(8'hA5 + k);
         pulse_start(0);
         wait_done(0, 4000);
         check_final(0, 1'b0);
         check_log(0, 8'h00, 8'hA5, 8, 0, k + 1);
         k = $urandom_range(1, 8);
         new_run(0, $urandom_range(1, 12));
         nack_at[0] = k;
         pulse_start(0);
         wait_done(0, 4000);
         check_final(0, 1'b0);
         check_log(0, 8'h00, 8'hA5, 8, k, 0);
      end
   endtask

   task automatic test_start_ignored_and_abort();
      logic [20:0] v;
      bit hit;
      new_run(0, $urandom_range(3, 12));
      pulse_start(0);
      hit = 1'b0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk); #1;
         if (log_q[0].size() >= 10 && ack_o[0]) hit = 1'b1;
      end
      start0 = 1'b1;
      @(negedge clk); #1;
      start0 = 1'b0;
      snap(0, v);
      n_checks++;
      if (!hit || v[2:0] !== 3'b001) begin
         n_fail++;
         $display("FAIL start_while_busy: reached=%b done/result/busy=%b, want reached=1 001", hit, v[2:0]);
      end
      wait_done(0, 3000);
      check_final(0, 1'b1);
      check_log(0, 8'h00, 8'hA5, 8, 0, 8);

      new_run(0, 10);
      pulse_start(0);
      hit = 1'b0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk); #1;
         if (log_q[0].size() == 4 && pend[0] != 0) hit = 1'b1;
      end
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      snap(0, v);
      n_checks++;
      if (!hit || v !== 21'd0) begin
         n_fail++;
         $display("FAIL abort_reset: reached=%b outputs=%h, want reached=1 000000", hit, v);
      end
      repeat (20) @(negedge clk);
      #1;
      snap(0, v);
      n_checks++;
      if (v[20] !== 1'b0 || log_q[0].size() != 4) begin
         n_fail++;
         $display("FAIL abort_quiet: req=%b txns=%0d, want req=0 txns=4", v[20], log_q[0].size());
      end
      new_run(0, 10);
      pulse_start(0);
      wait_done(0, 3000);
      check_final(0, 1'b1);
      check_log(0, 8'h00, 8'hA5, 8, 0, 8);
   endtask

   task automatic test_back_to_back();
      new_run(0, $urandom_range(1, 12));
      pulse_start(0);
      check_started(0, 8'h00, 8'hA5);
      wait_done(0, 4000);
      check_final(0, 1'b1);
      check_log(0, 8'h00, 8'hA5, 8, 0, 8);
   endtask

   initial begin
      test_reset();
      test_default_pass();
      test_corrupt_read();
      test_nack_write();
      test_wrap();
      test_random_faults();
      test_start_ignored_and_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
